aes128_decrypt_iter: RTL and testbench



---
 rtl/aes128_decrypt_iter_if.sv | 25 ++
 rtl/aes128_decrypt_iter.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_decrypt_iter_if
//  Description : Handshake/data bundle for the iterative AES-128 decryptor.
//                master = controller side, slave = decryption core side.
//                start : request pulse/level, sampled by the core in IDLE
//                in    : 128-bit ciphertext, in[127:120] = state byte 0
//                key   : 128-bit cipher key, same byte ordering
//                out   : 128-bit plaintext result
//                busy  : operation in progress
//                done  : one-cycle pulse when out becomes valid
//  Revision    : 1.0  initial release
// ============================================================================
interface aes128_decrypt_iter_if;
    logic         start;
    logic [127:0] in;
    logic [127:0] key;
    logic [127:0] out;
    logic         busy;
    logic         done;

    modport master (output start, in, key, input out, busy, done);
    modport slave  (input start, in, key, output out, busy, done);
endinterface
`default_nettype wire

// File: rtl/aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_decrypt_iter
//  Description : Iterative AES-128 decryption core (FIPS-197 inverse cipher).
//                A sequential key expansion fills an 11-entry round-key
//                store, then one inverse round is computed per clock.
//                Start to done is 21 clock edges.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - aes128_decrypt_iter_if.slave (start/in/key in,
//                       out/busy/done out)
//  Parameters  : CLEAR_OUT_WHEN_BUSY - 1: out reads 0 while busy,
//                                      0: out holds the last result
//  Options     : `define AES_DEC_KEY_CACHE_EN to keep the last expanded key;
//                a start with the same key skips expansion (11 edges).
//  Revision    : 1.0  initial release
// ============================================================================
module aes128_decrypt_iter #(
    parameter int CLEAR_OUT_WHEN_BUSY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    aes128_decrypt_iter_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_INIT   = 2'd2;
    localparam logic [1:0] S_ROUND  = 2'd3;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, same layout.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    // Byte a lives at bit offset (255-a)*8 = {~a, 3'b000}.
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        return SBOX_TBL[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] a);
        return INV_SBOX_TBL[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                    input logic [7:0]   rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {prev[23:0], prev[31:24]};                       // RotWord
        t  = {sub_byte(t[31:24]), sub_byte(t[23:16]),
              sub_byte(t[15:8]),  sub_byte(t[7:0])} ^ {rc, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte p = row + 4*col sits at bits [127-8p -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int p = 0; p < 16; p++) begin
            o[127 - 8*p -: 8] = inv_sub_byte(s[127 - 8*p -: 8]);
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] data_q;
    logic [127:0] st_q;
    logic [127:0] rk_q [0:10];
    logic [3:0]   rcon_idx_q;
    logic [3:0]   round_q;
    logic [127:0] out_q;
    logic         busy_q;
    logic         done_q;

    logic         w_accept;
    logic         w_hit;
    logic [127:0] w_next_rk;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    // The done cycle already has the FSM back in IDLE; masking start with
    // done_q makes a request coinciding with done wait one more cycle.
    assign w_accept = bus.start && !done_q;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cached_key_q;
    logic         cache_valid_q;

    assign w_hit = cache_valid_q && (bus.key == cached_key_q);
`else
    assign w_hit = 1'b0;
`endif

    assign w_next_rk = next_round_key(rk_q[rcon_idx_q - 4'd1], rcon(rcon_idx_q));
    assign w_ark     = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q[round_q];
    assign w_imc     = inv_mix_columns(w_ark);

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (w_accept) begin
                    fsm_d = w_hit ? S_INIT : S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (rcon_idx_q == 4'd10) begin
                    fsm_d = S_INIT;
                end
            end
            S_INIT: begin
                fsm_d = S_ROUND;
            end
            S_ROUND: begin
                if (round_q == 4'd0) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            data_q     <= '0;
            st_q       <= '0;
            rcon_idx_q <= 4'd0;
            round_q    <= 4'd0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                rk_q[i] <= '0;
            end
`ifdef AES_DEC_KEY_CACHE_EN
            cached_key_q  <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            done_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (w_accept) begin
                        data_q     <= bus.in;
                        rk_q[0]    <= bus.key;
                        rcon_idx_q <= 4'd1;
                        busy_q     <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    rk_q[rcon_idx_q] <= w_next_rk;
                    rcon_idx_q       <= rcon_idx_q + 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (rcon_idx_q == 4'd10) begin
                        cached_key_q  <= rk_q[0];
                        cache_valid_q <= 1'b1;
                    end
`endif
                end
                S_INIT: begin
                    st_q    <= data_q ^ rk_q[10];
                    round_q <= 4'd9;
                end
                S_ROUND: begin
                    if (round_q != 4'd0) begin
                        st_q    <= w_imc;
                        round_q <= round_q - 4'd1;
                    end else begin
                        // Final round has no InvMixColumns.
                        out_q  <= w_ark;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out  = ((CLEAR_OUT_WHEN_BUSY != 0) && busy_q) ? '0 : out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_decrypt_iter
//  Description : Self-checking bench for aes128_decrypt_iter. Two instances
//                (CLEAR_OUT_WHEN_BUSY = 0 and 1) receive identical stimulus;
//                results are compared with a byte-level FIPS-197 model whose
//                S-boxes are derived from GF(2^8) inversion at start-up.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_decrypt_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes128_decrypt_iter_if bus0 ();
    aes128_decrypt_iter_if bus1 ();

    aes128_decrypt_iter #(.CLEAR_OUT_WHEN_BUSY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    aes128_decrypt_iter #(.CLEAR_OUT_WHEN_BUSY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    // Model of the optional key cache: last fully used key.
    bit           c_valid = 1'b0;
    logic [127:0] c_key   = '0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_tables();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[a]  = s;
            isb[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int p = 0; p < 16; p++) s[p] = ct[127 - 8*p -: 8] ^ w[40 + p/4][31 - 8*(p%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c - row + 4) % 4)];
            for (int p = 0; p < 16; p++) s[p] = isb[t[p]] ^ w[4*r + p/4][31 - 8*(p%4) -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) begin
                        t[i + 4*c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            t[i + 4*c] = t[i + 4*c] ^ gmul(coef[(j - i + 4) % 4], s[j + 4*c]);
                    end
                end
                for (int p = 0; p < 16; p++) s[p] = t[p];
            end
        end
        res = '0;
        for (int p = 0; p < 16; p++) res[127 - 8*p -: 8] = s[p];
        return res;
    endfunction

    function automatic int exp_lat(input logic [127:0] k);
        return (CACHE_EN && c_valid && (k == c_key)) ? 11 : 21;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic s, input logic [127:0] c, input logic [127:0] k);
        bus0.start = s; bus0.in = c; bus0.key = k;
        bus1.start = s; bus1.in = c; bus1.key = k;
    endtask

    // One idle cycle, a one-cycle start, then in/key scrambled every cycle
    // until done. Returns at the sample just after done rises.
    task automatic run_op(input  logic [127:0] k, input logic [127:0] c,
                          output logic [127:0] got0, output logic [127:0] got1,
                          output int lat, output bit busy_done,
                          output bit bad_clear, output bit bad_hold, output bit bad_dwb);
        logic [127:0] prev0;
        drive(1'b0, c, k);
        @(posedge clk); #1;
        prev0 = bus0.out;
        drive(1'b1, c, k);
        @(posedge clk); #1;
        lat = -1; busy_done = 1'b0; bad_clear = 1'b0; bad_hold = 1'b0; bad_dwb = 1'b0;
        got0 = '0; got1 = '0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (bus0.busy && (bus0.out !== prev0)) bad_hold = 1'b1;
            if (bus1.busy && (bus1.out !== 128'h0)) bad_clear = 1'b1;
            if ((bus0.busy && bus0.done) || (bus1.busy && bus1.done)) bad_dwb = 1'b1;
            if (bus0.done) begin
                lat = n; got0 = bus0.out; got1 = bus1.out;
                busy_done = bus0.busy | bus1.busy;
                break;
            end
            drive(1'b0, rnd128(), rnd128());
        end
        if (lat >= 0) begin
            c_key = k; c_valid = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus0.out !== 128'h0) $display("FAIL reset_out0 got %h want 0", bus0.out); else n_pass++;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy0 got %b want 0", bus0.busy); else n_pass++;
        n_total++; if (bus0.done !== 1'b0) $display("FAIL reset_done0 got %b want 0", bus0.done); else n_pass++;
        n_total++; if (bus1.out !== 128'h0) $display("FAIL reset_out1 got %h want 0", bus1.out); else n_pass++;
        n_total++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy1 got %b want 0", bus1.busy); else n_pass++;
        rst = 1'b0;
        c_valid = 1'b0;
    endtask

    task automatic test_known_vectors();
        logic [127:0] g0, g1;
        int lat, e;
        bit bd, bc, bh, bw;
        e = exp_lat(K1);
        run_op(K1, C1, g0, g1, lat, bd, bc, bh, bw);
        n_total++; if (g0 !== P1) $display("FAIL v1_out0 got %h want %h", g0, P1); else n_pass++;
        n_total++; if (g1 !== P1) $display("FAIL v1_out1 got %h want %h", g1, P1); else n_pass++;
        n_total++; if (lat !== 21 || e !== 21) $display("FAIL v1_latency got %0d want 21", lat); else n_pass++;
        n_total++; if (bd !== 1'b0) $display("FAIL v1_busy_on_done got %b want 0", bd); else n_pass++;
        n_total++; if (bc !== 1'b0) $display("FAIL v1_clear_while_busy got %b want 0", bc); else n_pass++;
        n_total++; if (bh !== 1'b0) $display("FAIL v1_hold_while_busy got %b want 0", bh); else n_pass++;
        n_total++; if (bw !== 1'b0) $display("FAIL v1_done_with_busy got %b want 0", bw); else n_pass++;
        e = exp_lat(K2);
        run_op(K2, C2, g0, g1, lat, bd, bc, bh, bw);
        n_total++; if (g0 !== P2) $display("FAIL v2_out0 got %h want %h", g0, P2); else n_pass++;
        n_total++; if (g1 !== P2) $display("FAIL v2_out1 got %h want %h", g1, P2); else n_pass++;
        n_total++; if (lat !== e) $display("FAIL v2_latency got %0d want %0d", lat, e); else n_pass++;
        n_total++; if (bh !== 1'b0 || bc !== 1'b0) $display("FAIL v2_out_while_busy got hold=%b clear=%b want 0 0", bh, bc); else n_pass++;
    endtask

    task automatic test_key_cache();
        logic [127:0] g0, g1, k3, c3, p3;
        int lat, e;
        bit bd, bc, bh, bw;
        for (int rep = 0; rep < 2; rep++) begin
            e = exp_lat(K1);
            run_op(K1, C1, g0, g1, lat, bd, bc, bh, bw);
            n_total++; if (g0 !== P1) $display("FAIL cache_rep%0d_out got %h want %h", rep, g0, P1); else n_pass++;
            n_total++; if (lat !== e) $display("FAIL cache_rep%0d_latency got %0d want %0d", rep, lat, e); else n_pass++;
        end
        k3 = K1 ^ 128'h1;
        c3 = rnd128();
        p3 = ref_decrypt(k3, c3);
        e = exp_lat(k3);
        run_op(k3, c3, g0, g1, lat, bd, bc, bh, bw);
        n_total++; if (g0 !== p3) $display("FAIL cache_newkey_out got %h want %h", g0, p3); else n_pass++;
        n_total++; if (lat !== 21 || e !== 21) $display("FAIL cache_newkey_latency got %0d want 21", lat); else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] g0, g1, k, c, p;
        int lat, e;
        bit bd, bc, bh, bw;
        for (int i = 0; i < 6; i++) begin
            k = rnd128();
            c = rnd128();
            p = ref_decrypt(k, c);
            e = exp_lat(k);
            run_op(k, c, g0, g1, lat, bd, bc, bh, bw);
            n_total++; if (g0 !== p || g1 !== p) $display("FAIL rand%0d_out got %h/%h want %h", i, g0, g1, p); else n_pass++;
            n_total++; if (lat !== e) $display("FAIL rand%0d_latency got %0d want %0d", i, lat, e); else n_pass++;
            n_total++; if (bc || bh || bw || bd) $display("FAIL rand%0d_busy_rules got clear=%b hold=%b dwb=%b bd=%b want 0", i, bc, bh, bw, bd); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] g0, g1;
        int lat, e;
        bit bd, bc, bh, bw;
        run_op(K2, C2, g0, g1, lat, bd, bc, bh, bw);
        n_total++; if (g0 !== P2) $display("FAIL b2b_first_out got %h want %h", g0, P2); else n_pass++;
        // Now in the done cycle: raise start and hold it for two edges.
        drive(1'b1, C1, K1);
        @(posedge clk); #1;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL b2b_start_on_done_ignored got busy=%b want 0", bus0.busy); else n_pass++;
        e = exp_lat(K1);
        @(posedge clk); #1;
        n_total++; if (bus0.busy !== 1'b1) $display("FAIL b2b_next_cycle_accepted got busy=%b want 1", bus0.busy); else n_pass++;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            drive(1'b0, rnd128(), rnd128());
            @(posedge clk); #1;
            if (bus0.done) begin
                lat = n;
                break;
            end
        end
        n_total++; if (lat !== e) $display("FAIL b2b_latency got %0d want %0d", lat, e); else n_pass++;
        n_total++; if (bus0.out !== P1 || bus1.out !== P1) $display("FAIL b2b_second_out got %h/%h want %h", bus0.out, bus1.out, P1); else n_pass++;
        if (lat >= 0) begin
            c_key = K1; c_valid = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] g0, g1, k, c, p;
        int lat, e;
        bit bd, bc, bh, bw, saw_done;
        drive(1'b0, C2, K2);
        @(posedge clk); #1;
        drive(1'b1, C2, K2);
        @(posedge clk); #1;                 // edge k
        drive(1'b0, rnd128(), rnd128());
        repeat (14) @(posedge clk);         // edges k+1 .. k+14
        #1;
        rst = 1'b1;
        @(posedge clk); #1;                 // edge k+15 samples rst
        n_total++; if (bus0.out !== 128'h0) $display("FAIL rstmid_out got %h want 0", bus0.out); else n_pass++;
        n_total++; if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) $display("FAIL rstmid_busy got %b/%b want 0", bus0.busy, bus1.busy); else n_pass++;
        rst = 1'b0;
        c_valid = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (bus0.done || bus1.done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        n_total++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", saw_done); else n_pass++;
        k = rnd128();
        c = rnd128();
        p = ref_decrypt(k, c);
        e = exp_lat(k);
        run_op(k, c, g0, g1, lat, bd, bc, bh, bw);
        n_total++; if (g0 !== p) $display("FAIL rstmid_after_out got %h want %h", g0, p); else n_pass++;
        n_total++; if (lat !== 21 || e !== 21) $display("FAIL rstmid_after_latency got %0d want 21", lat); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0);
        build_tables();
        test_reset();
        test_known_vectors();
        test_key_cache();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
